// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronized serial input, bit-period counter, 8N1 framing
// (8E1 when UART_RX_PARITY_EN is defined) and a single valid/ready holding register.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_WIDTH    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun_err,
    output logic       busy
);

    // Handshake: a byte transfers on any rising edge where rx_valid & rx_ready;
    // rx_data is held stable for as long as rx_valid is high.

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    localparam logic [CNT_WIDTH-1:0] LP_HALF_END = CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_WIDTH-1:0] LP_BIT_END  = CNT_WIDTH'(CLKS_PER_BIT - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic [2:0]           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [2:0]           r_idx;
    logic [7:0]           r_shift;
    logic                 r_frame_err;
    logic [7:0]           r_data;
    logic                 r_valid;
    logic                 r_overrun;
    logic                 w_rx_s;
    logic                 w_bit_end;
    logic                 w_par_ok;
    logic                 w_deliver;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s    = r_sync2;
    assign w_bit_end = (r_cnt == LP_BIT_END);

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_par_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par_bad <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= 1'b0;
            if (r_state == ST_PARITY && w_bit_end) begin
                r_par_bad <= w_rx_s ^ (^r_shift);
                r_par_err <= w_rx_s ^ (^r_shift);
            end
        end
    end

    assign w_par_ok   = ~r_par_bad;
    assign parity_err = r_par_err;
`else
    assign w_par_ok   = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                    end
                end
                ST_START: begin
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (r_cnt == LP_HALF_END) begin
                        r_cnt   <= '0;
                        r_idx   <= 3'd0;
                        r_state <= w_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_deliver = (r_state == ST_STOP) && w_bit_end && w_rx_s && w_par_ok;

    // A consumer taking the old byte in the same cycle frees the register for the new one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_deliver) begin
                if (!r_valid || rx_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16: scoreboard queue of expected bytes,
// a negedge monitor that pops on each accepted transfer, and pulse counters for errors.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       reset;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int valid_cycles = 0;
    int frame_cnt = 0;
    int ovr_cnt = 0;
    int par_cnt = 0;
    int v0, f0, o0, p0;

    logic [7:0] exp_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB), .CNT_WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_in       (rx_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        valid_cycles += int'(rx_valid);
        frame_cnt    += int'(frame_err);
        ovr_cnt      += int'(overrun_err);
        par_cnt      += int'(parity_err);
        if (rx_valid && rx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte actual=%0h required=none", rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    errors++;
                    $display("FAIL rx_data actual=%0h required=%0h", rx_data, e);
                end
            end
        end
    end

    // driver tasks
    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_bit);
`endif
        drive_bit(stop_bit);
    endtask

    task automatic snap();
        v0 = valid_cycles;
        f0 = frame_cnt;
        o0 = ovr_cnt;
        p0 = par_cnt;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        rx_in    = 1'b1;
        rx_ready = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // reset state, idle line
        check("rst_rx_data", {24'd0, rx_data}, 32'h00);
        check("rst_rx_valid", {31'd0, rx_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_errs", {29'd0, frame_err, parity_err, overrun_err}, 0);

        // clean frame, consumer ready
        rx_ready = 1'b1;
        snap();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, ^8'hA5);
        idle(10);
        check("a5_valid_cycles", valid_cycles - v0, 1);
        check("a5_frame_err", frame_cnt - f0, 0);
        check("a5_overrun", ovr_cnt - o0, 0);
        check("a5_busy_after", {31'd0, busy}, 0);

        // 3-cycle glitch
        snap();
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy_mid", {31'd0, busy}, 1);
        idle(30);
        check("glitch_busy_after", {31'd0, busy}, 0);
        check("glitch_valid", valid_cycles - v0, 0);
        check("glitch_frame_err", frame_cnt - f0, 0);
        check("glitch_overrun", ovr_cnt - o0, 0);

        // framing error followed by a held-low line
        snap();
        send_frame(8'h3C, 1'b0, ^8'h3C);
        repeat (40) @(negedge clk);
        check("brk_busy_low", {31'd0, busy}, 1);
        check("brk_frame_pulses", frame_cnt - f0, 1);
        check("brk_valid", valid_cycles - v0, 0);
        idle(6);
        check("brk_busy_released", {31'd0, busy}, 0);

        // overrun: consumer stalled across two back-to-back frames
        rx_ready = 1'b0;
        snap();
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, ^8'h11);
        send_frame(8'h22, 1'b1, ^8'h22);
        idle(10);
        check("ovr_pulses", ovr_cnt - o0, 1);
        check("ovr_valid_held", {31'd0, rx_valid}, 1);
        check("ovr_data_held", {24'd0, rx_data}, 32'h11);
        check("ovr_frame_err", frame_cnt - f0, 0);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("ovr_valid_cleared", {31'd0, rx_valid}, 0);

        // reset in the middle of the data bits
        snap();
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        repeat (CPB / 2) @(negedge clk);
        check("mid_busy", {31'd0, busy}, 1);
        reset = 1'b1;
        rx_in = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_valid", {31'd0, rx_valid}, 0);
        check("mid_rst_data", {24'd0, rx_data}, 32'h00);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(20);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        idle(10);
        check("post_rst_valid", valid_cycles - v0, 1);
        check("post_rst_errs", (frame_cnt - f0) + (ovr_cnt - o0) + (par_cnt - p0), 0);

`ifdef UART_RX_PARITY_EN
        // even parity: good then bad parity bit
        snap();
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(10);
        check("par_ok_valid", valid_cycles - v0, 1);
        check("par_ok_err", par_cnt - p0, 0);
        snap();
        send_frame(8'h07, 1'b1, 1'b0);
        idle(10);
        check("par_bad_err", par_cnt - p0, 1);
        check("par_bad_valid", valid_cycles - v0, 0);
        check("par_bad_frame", frame_cnt - f0, 0);
`else
        check("noparity_tied", par_cnt, 0);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
